// File: rtl/hsv_effect_sequencer.sv
// HSV effect sequencer: accepts an effect configuration over valid/ready and steps
// Hue/Saturation/Value on a prescaler tick, with a strobe aligned to each HSV update.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no configuration yet, outputs parked at 0
//   LOAD    | one cycle applying the latched configuration to the outputs
//   RUN     | prescaler counting, effect advances on each tick
//   PAUSE   | outputs and prescaler frozen until enable returns
module hsv_effect_sequencer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [8:0]       cfg_hue,
  input  logic [8:0]       cfg_sat,
  input  logic [8:0]       cfg_val,
  input  logic [7:0]       cfg_step,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             enable,
  output logic [8:0]       Hue,
  output logic [8:0]       Saturation,
  output logic [8:0]       Value,
  output logic             busy,
  output logic             rgb_strobe
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  localparam logic [1:0] M_STATIC  = 2'd0;
  localparam logic [1:0] M_RAINBOW = 2'd1;
  localparam logic [1:0] M_BREATHE = 2'd2;
  localparam logic [1:0] M_BLINK   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       mode;
  logic [8:0]       hue_l;
  logic [8:0]       sat_l;
  logic [8:0]       peak;
  logic [7:0]       step;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] prescale;
  logic             dir_down;
  logic             phase_on;
  logic             handshake;
  logic [9:0]       hue_sum;
  logic [9:0]       hue_sub;
  logic [8:0]       hue_next;
  logic [9:0]       val_up;

  assign cfg_ready = (state != S_LOAD);
  assign busy      = (state != S_IDLE);
  assign handshake = cfg_valid && cfg_ready;

  // Sums are formed 10 bits wide so 359+255 and 100+255 cannot wrap.
  assign hue_sum  = {1'b0, Hue} + {2'b00, step};
  assign hue_sub  = hue_sum - 10'd360;
  assign hue_next = (hue_sum >= 10'd360) ? hue_sub[8:0] : hue_sum[8:0];
  assign val_up   = {1'b0, Value} + {2'b00, step};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mode       <= M_STATIC;
      hue_l      <= '0;
      sat_l      <= '0;
      peak       <= '0;
      step       <= '0;
      div        <= '0;
      prescale   <= '0;
      dir_down   <= 1'b0;
      phase_on   <= 1'b1;
      Hue        <= '0;
      Saturation <= '0;
      Value      <= '0;
      rgb_strobe <= 1'b0;
    end else begin
      rgb_strobe <= 1'b0;

      // Clamp at capture so LOAD and the effect arithmetic only see legal ranges.
      if (handshake) begin
        mode  <= cfg_mode;
        hue_l <= (cfg_hue > 9'd359) ? 9'd359 : cfg_hue;
        sat_l <= (cfg_sat > 9'd100) ? 9'd100 : cfg_sat;
        peak  <= (cfg_val > 9'd100) ? 9'd100 : cfg_val;
        step  <= cfg_step;
        div   <= cfg_div;
      end

      case (state)
        S_IDLE: begin
          if (handshake) state <= S_LOAD;
        end
        S_LOAD: begin
          Hue        <= hue_l;
          Saturation <= sat_l;
          Value      <= (mode == M_BREATHE) ? 9'd0 : peak;
          dir_down   <= 1'b0;
          phase_on   <= 1'b1;
          prescale   <= '0;
          rgb_strobe <= 1'b1;
          state      <= enable ? S_RUN : S_PAUSE;
        end
        S_RUN: begin
          if (handshake) begin
            state <= S_LOAD;
          end else if (!enable) begin
            state <= S_PAUSE;
          end else if (prescale == div) begin
            prescale   <= '0;
            rgb_strobe <= (mode != M_STATIC);
            case (mode)
              M_RAINBOW: Hue <= hue_next;
              M_BREATHE: begin
                if (!dir_down) begin
                  if (val_up >= {1'b0, peak}) begin
                    Value    <= peak;
                    dir_down <= 1'b1;
                  end else begin
                    Value <= val_up[8:0];
                  end
                end else begin
                  if (Value <= {1'b0, step}) begin
                    Value    <= 9'd0;
                    dir_down <= 1'b0;
                  end else begin
                    Value <= Value - {1'b0, step};
                  end
                end
              end
              M_BLINK: begin
                phase_on <= !phase_on;
                Value    <= phase_on ? 9'd0 : peak;
              end
              default: ;
            endcase
          end else begin
            prescale <= prescale + DIV_W'(1);
          end
        end
        S_PAUSE: begin
          if (handshake) state <= S_LOAD;
          else if (enable) state <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_effect_sequencer.sv
// Directed self-checking bench for hsv_effect_sequencer; one task per scenario.
module tb_hsv_effect_sequencer;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [8:0]  cfg_hue;
  logic [8:0]  cfg_sat;
  logic [8:0]  cfg_val;
  logic [7:0]  cfg_step;
  logic [23:0] cfg_div;
  logic        enable;
  logic [8:0]  Hue;
  logic [8:0]  Saturation;
  logic [8:0]  Value;
  logic        busy;
  logic        rgb_strobe;

  int tests;
  int fails;

  hsv_effect_sequencer #(.DIV_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_hue    (cfg_hue),
    .cfg_sat    (cfg_sat),
    .cfg_val    (cfg_val),
    .cfg_step   (cfg_step),
    .cfg_div    (cfg_div),
    .enable     (enable),
    .Hue        (Hue),
    .Saturation (Saturation),
    .Value      (Value),
    .busy       (busy),
    .rgb_strobe (rgb_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake, then scramble the cfg inputs so LOAD must use the captured copy.
  task automatic do_load(input logic [1:0] m, input logic [8:0] h, input logic [8:0] s,
                         input logic [8:0] v, input logic [7:0] st, input logic [23:0] d);
    cfg_mode  = m;
    cfg_hue   = h;
    cfg_sat   = s;
    cfg_val   = v;
    cfg_step  = st;
    cfg_div   = d;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    cfg_mode  = ~m;
    cfg_hue   = 9'd77;
    cfg_sat   = 9'd33;
    cfg_val   = 9'd11;
    cfg_step  = 8'd99;
    cfg_div   = 24'd5;
    tests++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load_cycle: ready=%b busy=%b, want ready=0 busy=1", cfg_ready, busy);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    tests++;
    if (Hue !== 9'd0 || Saturation !== 9'd0 || Value !== 9'd0 || cfg_ready !== 1'b1 ||
        busy !== 1'b0 || rgb_strobe !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: H=%0d S=%0d V=%0d ready=%b busy=%b strobe=%b, want 0/0/0/1/0/0",
               Hue, Saturation, Value, cfg_ready, busy, rgb_strobe);
    end
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    tests++;
    if (busy !== 1'b0 || rgb_strobe !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: busy=%b strobe=%b, want 0/0", busy, rgb_strobe);
    end
  endtask

  task automatic test_rainbow();
    enable = 1'b1;
    do_load(2'd1, 9'd350, 9'd100, 9'd100, 8'd20, 24'd0);
    tests++;
    if (Hue !== 9'd350 || rgb_strobe !== 1'b1) begin
      fails++;
      $display("FAIL rainbow_load: H=%0d strobe=%b, want 350/1", Hue, rgb_strobe);
    end
    step();
    tests++;
    if (Hue !== 9'd10 || rgb_strobe !== 1'b1) begin
      fails++;
      $display("FAIL rainbow_wrap: H=%0d strobe=%b, want 10/1", Hue, rgb_strobe);
    end
    step();
    tests++;
    if (Hue !== 9'd30 || rgb_strobe !== 1'b1) begin
      fails++;
      $display("FAIL rainbow_step: H=%0d strobe=%b, want 30/1", Hue, rgb_strobe);
    end
  endtask

  task automatic test_breathe();
    logic [8:0] exp_seq [7];
    logic [8:0] prev;
    exp_seq = '{9'd20, 9'd40, 9'd50, 9'd30, 9'd10, 9'd0, 9'd20};
    enable = 1'b1;
    do_load(2'd2, 9'd0, 9'd100, 9'd50, 8'd20, 24'd3);
    tests++;
    if (Value !== 9'd0 || Saturation !== 9'd100 || rgb_strobe !== 1'b1) begin
      fails++;
      $display("FAIL breathe_load: V=%0d S=%0d strobe=%b, want 0/100/1", Value, Saturation, rgb_strobe);
    end
    prev = 9'd0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        tests++;
        if (Value !== prev || rgb_strobe !== 1'b0) begin
          fails++;
          $display("FAIL breathe_hold[%0d.%0d]: V=%0d strobe=%b, want %0d/0", i, j, Value, rgb_strobe, prev);
        end
      end
      step();
      tests++;
      if (Value !== exp_seq[i] || rgb_strobe !== 1'b1) begin
        fails++;
        $display("FAIL breathe_tick[%0d]: V=%0d strobe=%b, want %0d/1", i, Value, rgb_strobe, exp_seq[i]);
      end
      prev = exp_seq[i];
    end
  endtask

  task automatic test_blink_pause();
    logic [8:0] exp_v [4];
    logic       exp_s [4];
    enable = 1'b1;
    do_load(2'd3, 9'd0, 9'd100, 9'd80, 8'd1, 24'd1);
    tests++;
    if (Value !== 9'd80 || rgb_strobe !== 1'b1) begin
      fails++;
      $display("FAIL blink_load: V=%0d strobe=%b, want 80/1", Value, rgb_strobe);
    end
    exp_v = '{9'd80, 9'd0, 9'd0, 9'd80};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (Value !== exp_v[i] || rgb_strobe !== exp_s[i]) begin
        fails++;
        $display("FAIL blink_run[%0d]: V=%0d strobe=%b, want %0d/%b", i, Value, rgb_strobe, exp_v[i], exp_s[i]);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (Value !== 9'd80 || rgb_strobe !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL blink_pause[%0d]: V=%0d strobe=%b busy=%b, want 80/0/1", i, Value, rgb_strobe, busy);
      end
    end
    enable = 1'b1;
    exp_v = '{9'd80, 9'd80, 9'd0, 9'd0};
    exp_s = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (Value !== exp_v[i] || rgb_strobe !== exp_s[i]) begin
        fails++;
        $display("FAIL blink_resume[%0d]: V=%0d strobe=%b, want %0d/%b", i, Value, rgb_strobe, exp_v[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_load_paused();
    enable = 1'b0;
    do_load(2'd1, 9'd100, 9'd40, 9'd60, 8'd5, 24'd0);
    tests++;
    if (Hue !== 9'd100 || Saturation !== 9'd40 || Value !== 9'd60 || rgb_strobe !== 1'b1) begin
      fails++;
      $display("FAIL paused_load: H=%0d S=%0d V=%0d strobe=%b, want 100/40/60/1", Hue, Saturation, Value, rgb_strobe);
    end
    step();
    tests++;
    if (Hue !== 9'd100 || rgb_strobe !== 1'b0) begin
      fails++;
      $display("FAIL paused_hold: H=%0d strobe=%b, want 100/0", Hue, rgb_strobe);
    end
    enable = 1'b1;
    step();
    step();
    tests++;
    if (Hue !== 9'd105 || rgb_strobe !== 1'b1) begin
      fails++;
      $display("FAIL paused_resume: H=%0d strobe=%b, want 105/1", Hue, rgb_strobe);
    end
  endtask

  task automatic test_clamp();
    int strobes;
    enable = 1'b1;
    do_load(2'd0, 9'd400, 9'd150, 9'd255, 8'd5, 24'd0);
    tests++;
    if (Hue !== 9'd359 || Saturation !== 9'd100 || Value !== 9'd100 || rgb_strobe !== 1'b1) begin
      fails++;
      $display("FAIL clamp_load: H=%0d S=%0d V=%0d strobe=%b, want 359/100/100/1", Hue, Saturation, Value, rgb_strobe);
    end
    strobes = 0;
    repeat (10) begin
      step();
      if (rgb_strobe === 1'b1) strobes++;
    end
    tests++;
    if (strobes != 0 || Hue !== 9'd359 || Value !== 9'd100) begin
      fails++;
      $display("FAIL static_hold: extra strobes=%0d H=%0d V=%0d, want 0/359/100", strobes, Hue, Value);
    end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    do_load(2'd1, 9'd0, 9'd50, 9'd60, 8'd10, 24'd0);
    step();
    tests++;
    if (Hue !== 9'd10) begin
      fails++;
      $display("FAIL b2b_pre: H=%0d, want 10", Hue);
    end
    cfg_mode  = 2'd0;
    cfg_hue   = 9'd120;
    cfg_sat   = 9'd20;
    cfg_val   = 9'd30;
    cfg_step  = 8'd10;
    cfg_div   = 24'd0;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    tests++;
    if (Hue !== 9'd10 || rgb_strobe !== 1'b0 || cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_discard: H=%0d strobe=%b ready=%b, want 10/0/0", Hue, rgb_strobe, cfg_ready);
    end
    step();
    tests++;
    if (Hue !== 9'd120 || Saturation !== 9'd20 || Value !== 9'd30 || rgb_strobe !== 1'b1 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_load: H=%0d S=%0d V=%0d strobe=%b ready=%b, want 120/20/30/1/1",
               Hue, Saturation, Value, rgb_strobe, cfg_ready);
    end
    step();
    tests++;
    if (Hue !== 9'd120 || rgb_strobe !== 1'b0) begin
      fails++;
      $display("FAIL b2b_static: H=%0d strobe=%b, want 120/0", Hue, rgb_strobe);
    end
  endtask

  task automatic test_reset_midrun();
    int bad;
    enable = 1'b1;
    do_load(2'd1, 9'd0, 9'd100, 9'd100, 8'd7, 24'd0);
    step();
    step();
    tests++;
    if (Hue !== 9'd14) begin
      fails++;
      $display("FAIL midrun_pre: H=%0d, want 14", Hue);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (Hue !== 9'd0 || Saturation !== 9'd0 || Value !== 9'd0 || busy !== 1'b0 ||
        cfg_ready !== 1'b1 || rgb_strobe !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: H=%0d S=%0d V=%0d busy=%b ready=%b strobe=%b, want 0/0/0/0/1/0",
               Hue, Saturation, Value, busy, cfg_ready, rgb_strobe);
    end
    step();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rgb_strobe !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || Hue !== 9'd0 || Value !== 9'd0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL post_reset_quiet: %0d bad cycles, want 0", bad);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    cfg_hue   = 9'd0;
    cfg_sat   = 9'd0;
    cfg_val   = 9'd0;
    cfg_step  = 8'd0;
    cfg_div   = 24'd0;
    enable    = 1'b0;
    test_reset();
    test_rainbow();
    test_breathe();
    test_blink_pause();
    test_load_paused();
    test_clamp();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
